// File: rtl/subst_pkg.sv
// Shared types and helpers for the streaming neighbour-sum substitution stage.
// Used by subst_stream and its line buffer.
package subst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Wide enough for p + 3F with PIX_W up to 31 bits.
    localparam int RED_W = 34;

    // Brings any x in [0,4f) into [0,f) with three conditional subtracts, no divider.
    function automatic logic [RED_W-1:0] mod_reduce(input logic [RED_W-1:0] x,
                                                    input logic [RED_W-1:0] f);
        logic [RED_W-1:0] r;
        r = x;
        for (int i = 0; i < 3; i++) begin
            if (r >= f) begin
                r = r - f;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/subst_line_buf.sv
// One-row line buffer: combinational read and registered write at the same
// column address, so a read in the write cycle returns the previous row's pixel.
module subst_line_buf #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 256,
    parameter int ADDR_W = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wdata,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem_q [IMG_W];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/subst_stream.sv
// Streaming neighbour-sum substitution (encrypt) and its inverse (decrypt), one pixel
// per handshake. Define SUBST_RANGE_CHECK_EN to build the sticky out-of-domain err flag.
module subst_stream
    import subst_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [PIX_W-1:0] key_m,
    input  logic [PIX_W-1:0] key_n,
    input  logic [PIX_W:0]   key_f,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             mode_q, mode_d;
    logic [PIX_W-1:0] km_q, km_d;
    logic [PIX_W-1:0] kn_q, kn_d;
    logic [PIX_W:0]   f_q, f_d;
    logic [PIX_W-1:0] l_q, l_d;
    logic [PIX_W-1:0] ul_q, ul_d;
    logic             m_valid_q, m_valid_d;
    logic [PIX_W-1:0] m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic             done_q, done_d;

    logic [PIX_W-1:0] up;
    logic [PIX_W-1:0] result;
    logic [PIX_W-1:0] plain;
    logic [RED_W-1:0] terms;
    logic [RED_W-1:0] f_ext;
    logic [RED_W-1:0] pre_red;
    logic             accept;
    logic             last_pix;
    logic             key_ok;

    assign s_ready  = (state_q == RUN) && (!m_valid_q || m_ready);
    assign accept   = s_valid && s_ready;
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
    // Legal modulus is 1..2^PIX_W: either the top bit is clear, or it is exactly 2^PIX_W.
    assign key_ok   = (key_f != '0) && (!key_f[PIX_W] || (key_f[PIX_W-1:0] == '0));

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    subst_line_buf #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .ADDR_W(COL_W)
    ) u_line_buf (
        .clk  (clk),
        .we   (accept),
        .addr (col_q),
        .wdata(plain),
        .rdata(up)
    );

    // Neighbours are always plaintext; decrypt adds 3F so the subtraction never underflows.
    always_comb begin
        terms = '0;
        f_ext = RED_W'(f_q);
        if (row_q == '0 && col_q == '0) begin
            terms = RED_W'(kn_q);
        end else if (row_q == '0) begin
            terms = RED_W'(km_q);
        end else if (col_q == '0) begin
            terms = RED_W'(up);
        end else begin
            terms = RED_W'(l_q) + RED_W'(up) + RED_W'(ul_q);
        end
        if (mode_q == MODE_DEC) begin
            pre_red = RED_W'(s_data) + (f_ext << 1) + f_ext - terms;
        end else begin
            pre_red = RED_W'(s_data) + terms;
        end
        result = PIX_W'(mod_reduce(pre_red, f_ext));
        plain  = (mode_q == MODE_ENC) ? s_data : result;
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        mode_d    = mode_q;
        km_d      = km_q;
        kn_d      = kn_q;
        f_d       = f_q;
        l_d       = l_q;
        ul_d      = ul_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && key_ok) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                    mode_d  = mode;
                    km_d    = key_m;
                    kn_d    = key_n;
                    f_d     = key_f;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_pix) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_valid_q && m_ready && m_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The output register only moves when empty or drained, so data holds under backpressure.
        if (accept) begin
            l_d       = plain;
            ul_d      = up;
            m_valid_d = 1'b1;
            m_data_d  = result;
            m_last_d  = last_pix;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            mode_q    <= MODE_ENC;
            km_q      <= '0;
            kn_q      <= '0;
            f_q       <= '0;
            l_q       <= '0;
            ul_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            mode_q    <= mode_d;
            km_q      <= km_d;
            kn_q      <= kn_d;
            f_q       <= f_d;
            l_q       <= l_d;
            ul_q      <= ul_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
        end
    end

`ifdef SUBST_RANGE_CHECK_EN
    logic err_q, err_d;

    // A fresh frame restarts the flag, seeded by whether its own keys are in range.
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && start && key_ok) begin
            err_d = ({1'b0, key_m} >= key_f) || ({1'b0, key_n} >= key_f);
        end else if (accept && ({1'b0, s_data} >= f_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_subst_stream.sv
// Scoreboard bench for subst_stream: a plain-arithmetic reference model fills an
// expected queue as pixels are accepted; a monitor pops and compares every output.
module tb_subst_stream;

    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int NPIX  = IMG_W * IMG_H;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [7:0]   key_m;
    logic [7:0]   key_n;
    logic [8:0]   key_f;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [7:0]   m_data;
    logic         m_last;
    logic         busy;
    logic         done;
    logic         err;

    subst_stream #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .key_m  (key_m),
        .key_n  (key_n),
        .key_f  (key_f),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_last (m_last),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    bit   rand_ready  = 1'b0;
    int   img[NPIX];
    int   ref_out[NPIX];
    int   orig[NPIX];

    // Reference: neighbour terms taken from the plaintext image, arithmetic with plain %.
    function automatic void refModel(input bit dec, input int m, input int n, input int f);
        int plain[NPIX];
        int t;
        int r;
        int c;
        for (int i = 0; i < NPIX; i++) begin
            r = i / IMG_W;
            c = i % IMG_W;
            if (r == 0 && c == 0)      t = n;
            else if (r == 0)           t = m;
            else if (c == 0)           t = plain[i-IMG_W];
            else                       t = plain[i-1] + plain[i-IMG_W] + plain[i-IMG_W-1];
            if (!dec) begin
                ref_out[i] = (img[i] + t) % f;
                plain[i]   = img[i];
            end else begin
                ref_out[i] = (((img[i] - t) % f) + f) % f;
                plain[i]   = ref_out[i];
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) done_cnt++;
            if (m_valid && !m_ready) checkOutput("s_ready_under_stall", 32'(s_ready), 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_output: got data %0d with empty queue", m_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("m_data", 32'(m_data), 32'(e.data));
                    checkOutput("m_last", 32'(m_last), 32'(e.last));
                end
            end
        end
    end

    task automatic startFrame(input bit dec, input int m, input int n, input int f);
        start = 1'b1;
        mode  = dec;
        key_m = 8'(m);
        key_n = 8'(n);
        key_f = 9'(f);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_start", 32'(busy), (f >= 1 && f <= 256) ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit dec, input int m, input int n, input int f,
                                 input int count);
        int   idx;
        int   guard;
        int   d0;
        exp_t e;
        d0 = done_cnt;
        startFrame(dec, m, n, f);
        idx   = 0;
        guard = 0;
        while (idx < count && guard < 1000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'(img[idx]);
            @(negedge clk);
            if (s_valid && s_ready) begin
                e.data = 8'(ref_out[idx]);
                e.last = (idx == NPIX - 1);
                exp_q.push_back(e);
                idx++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        checkOutput("pixels_accepted", idx, count);
        if (count == NPIX) begin
            guard = 0;
            while (!(exp_q.size() == 0 && done_cnt != d0) && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            checkOutput("done_count", done_cnt, d0 + 1);
            checkOutput("queue_drained", exp_q.size(), 0);
            checkOutput("busy_after_done", 32'(busy), 0);
        end
    endtask

    initial begin
        int d_before;
        int f;
        int m;
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        key_m   = '0;
        key_n   = '0;
        key_f   = '0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_s_ready", 32'(s_ready), 0);
        checkOutput("rst_m_valid", 32'(m_valid), 0);
        checkOutput("rst_m_data", 32'(m_data), 0);
        checkOutput("rst_m_last", 32'(m_last), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] encrypt all-zero image");
        foreach (img[i]) img[i] = 0;
        refModel(0, 5, 7, 256);
        applyStimulus(0, 5, 7, 256, NPIX);

        $display("[TB] encrypt constant-100 image");
        foreach (img[i]) img[i] = 100;
        refModel(0, 5, 7, 256);
        applyStimulus(0, 5, 7, 256, NPIX);

        $display("[TB] F=251 round trip");
        foreach (img[i]) img[i] = $urandom_range(0, 250);
        orig = img;
        refModel(0, 17, 201, 251);
        applyStimulus(0, 17, 201, 251, NPIX);
        img     = ref_out;
        ref_out = orig;
        applyStimulus(1, 17, 201, 251, NPIX);

        $display("[TB] F=1 degenerate modulus");
        foreach (img[i]) img[i] = 0;
        refModel(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, NPIX);

        $display("[TB] random frames with output backpressure");
        rand_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            f = $urandom_range(2, 256);
            m = $urandom_range(0, f - 1);
            n = $urandom_range(0, f - 1);
            foreach (img[i]) img[i] = $urandom_range(0, f - 1);
            refModel(k[0], m, n, f);
            applyStimulus(k[0], m, n, f, NPIX);
        end
        rand_ready = 1'b0;

        $display("[TB] reset mid-frame then fresh frame");
        d_before = done_cnt;
        foreach (img[i]) img[i] = $urandom_range(0, 199);
        refModel(0, 3, 9, 200);
        applyStimulus(0, 3, 9, 200, 5);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_done_on_abort", done_cnt, d_before);
        foreach (img[i]) img[i] = $urandom_range(0, 120);
        refModel(0, 44, 90, 121);
        applyStimulus(0, 44, 90, 121, NPIX);

        $display("[TB] illegal modulus is ignored");
        startFrame(0, 1, 1, 0);
        startFrame(0, 1, 1, 257);

`ifdef SUBST_RANGE_CHECK_EN
        $display("[TB] range error flag");
        foreach (img[i]) img[i] = $urandom_range(0, 250);
        img[1] = 252;
        refModel(0, 5, 7, 251);
        applyStimulus(0, 5, 7, 251, NPIX);
        checkOutput("err_sticky", 32'(err), 1);
        startFrame(0, 5, 7, 251);
        checkOutput("err_cleared", 32'(err), 0);
`else
        checkOutput("err_tied_low", 32'(err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/subst_stream.md
# subst_stream

Streaming, parametrised successor to the array-based chaos substitution stage, and the bridge between the pixel scrambler and the output writer in the FPGA image-encryption path. It accepts one pixel per valid/ready handshake in raster order. It applies the neighbour-sum substitution modulo F in the forward direction (encrypt) or its exact inverse (decrypt). A one-row line buffer replaces the full-frame array, and keys are latched per frame.

## Interface
- PIX_W, 8: pixel width in bits.
- IMG_W, 256: pixels per row (≥2).
- IMG_H, 256: rows per frame (≥2).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start; latches mode/keys.
- mode  in  1  0 = encrypt, 1 = decrypt.
- key_m  in  PIX_W  row-0 key M (must be < F).
- key_n  in  PIX_W  origin key N (must be < F).
- key_f  in  PIX_W+1  modulus F, legal range 1..2^PIX_W.
- s_valid / s_ready  in / out  1  input handshake.
- s_data  in  PIX_W  input pixel.
- m_valid / m_ready  out / in  1  output handshake.
- m_data  out  PIX_W  output pixel.
- m_last  out  1  high with the final pixel of the frame.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse after the last output handshake.
- err  out  1  sticky range error; present only when SUBST_RANGE_CHECK_EN is defined.

## Operation
- States:
  - IDLE: on `start` with key_f in 1..2^PIX_W, latch keys, clear row/col counters, go to RUN. An illegal key_f is ignored and the block stays in IDLE.
  - RUN: accept pixels. When pixel IMG_W·IMG_H−1 is accepted, go to DRAIN.
  - DRAIN: when the last pixel's output handshake completes, pulse `done` and go to IDLE.
  - `start` in RUN or DRAIN is ignored.
- Neighbours use plaintext only: left L, up U, up-left UL. In encrypt, plaintext is s_data. In decrypt, plaintext is the computed result.
- Forward, for pixel p at (r,c):
  - (0,0): (p+N) mod F
  - r=0, c>0: (p+M) mod F
  - r>0, c=0: (p+U) mod F
  - otherwise: (p+L+U+UL) mod F
- Inverse uses the same cases with subtraction: the result is (p − terms) mod F.
- Arithmetic:
  - Forward sum width is PIX_W+2, range < 4F.
  - Inverse computes p + 3F − terms, also in range [0,4F).
  - Either value is reduced by three cascaded conditional subtracts of F. No divider.
- Line buffer: IMG_W entries. Read and write at column c in the same cycle, with read-old/write-new semantics. UL is the previous cycle's U, held in a register. L is a register.
- Pixels ≥ F, or M/N ≥ F, are out of domain and the result is unspecified (see Configuration).

## Timing
- Latency is 1 cycle: a pixel accepted at edge k appears on m_data after edge k.
- s_ready = (state==RUN) && (!m_valid || m_ready). There are no bubbles under continuous flow, so throughput is 1 pixel/clk.
- m_valid/m_data/m_last are held stable while m_valid && !m_ready.
- Column counter wraps IMG_W−1→0 and increments the row counter.
- Reset values: s_ready 0, m_valid 0, m_data 0, m_last 0, busy 0, done 0, err 0, state IDLE.
- Line buffer contents are not cleared; row 0 never reads them.
- rst mid-frame aborts the frame with no done pulse. The next start behaves as a fresh frame.

## Configuration
- SUBST_RANGE_CHECK_EN defined:
  - err is set when an accepted pixel, or latched M/N, is ≥ F.
  - err clears on the next accepted start.
  - Output is still produced.
- Undefined: no comparators are built and err is driven 0.

## Structure
- Package subst_pkg holds the state enum (IDLE/RUN/DRAIN), the mode constants, and a mod-reduce function (three conditional subtracts).
- Sub-module subst_line_buf: IMG_W×PIX_W register array, single read/write address, read-old.

## Test plan
- Encrypt IMG_W=4, IMG_H=3, all-zero image, M=5, N=7, F=256 → row 0 = 7,5,5,5; col 0 of rows 1–2 = 0; interior = 0; m_last on the 12th pixel, then done.
- Encrypt constant 100, M=5, N=7, F=256 → (0,0)=107; row 0 = 105; col 0 = 200; interior = 144.
- Random image with pixels < 251, F=251: encrypt, then decrypt with the same keys → bit-exact original. F=1 → all outputs 0.
- m_ready random 50% duty → output sequence identical to free-flow, no loss or duplicate; s_ready low whenever m_valid && !m_ready.
- rst after 5 accepted pixels, then a new start with different keys → output matches the golden result for a fresh frame; no done for the aborted frame.
- With macro defined: F=251 and one pixel = 252 → err rises the cycle after acceptance, stays high, clears on the next start. start with key_f=0 → ignored, busy stays 0.
